// File: rtl/eth_pkg.sv
// Shared Ethernet constants and types for the receive-side frame checkers.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

  localparam int ETH_MIN_BYTES = 64;
  localparam int ETH_MAX_BYTES = 1518;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    EVAL = 2'd2
  } fcs_state_t;

endpackage

// File: rtl/crc32_step.sv
// Combinational CRC-32 advance over one beat; data bit 0 is the earliest wire bit.
module crc32_step
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = 2
) (
  input  logic [31:0]           crc_in,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [31:0]           crc_out
);

  logic [31:0] crc_tmp;
  logic        fb;

  // Shift the register once per data bit, LSB of the beat first.
  always_comb begin
    crc_tmp = crc_in;
    fb      = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      fb      = crc_tmp[31] ^ data[i];
      crc_tmp = {crc_tmp[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
    end
    crc_out = crc_tmp;
  end

endmodule

// File: rtl/fcs_check.sv
// Inline FCS/length/alignment checker for preamble-stripped Ethernet frames.
// The evaluation cycle is the first idle cycle after a frame (RX with axiiv=0),
// so status appears two cycles after the last beat and a new frame may start
// in the done cycle.
module fcs_check
  import eth_pkg::*;
#(
  parameter int          DATA_WIDTH  = 2,
  parameter int          MIN_BYTES   = ETH_MIN_BYTES,
  parameter int          MAX_BYTES   = ETH_MAX_BYTES,
  parameter logic [31:0] CRC_RESIDUE = CRC32_RESIDUE,
  parameter int          CNT_WIDTH   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             axiiv,
  input  logic [DATA_WIDTH-1:0]            axiid,
  output logic                             done,
  output logic                             kill,
  output logic                             err_crc,
  output logic                             err_short,
  output logic                             err_long,
  output logic                             err_align,
  output logic [$clog2(MAX_BYTES+2)-1:0]   frame_len,
  output logic [CNT_WIDTH-1:0]             good_cnt,
  output logic [CNT_WIDTH-1:0]             bad_cnt
);

  localparam int              LEN_W   = $clog2(MAX_BYTES + 2);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_BYTES + 1);

  if (DATA_WIDTH != 2 && DATA_WIDTH != 8) begin : g_bad_width
    $error("fcs_check: DATA_WIDTH must be 2 or 8, got %0d", DATA_WIDTH);
  end

  fcs_state_t       state_reg, state_cur;
  logic [31:0]      crc_reg, crc_base, crc_next;
  logic [2:0]       bit_reg, bit_base, bit_next;
  logic [LEN_W-1:0] byte_reg, byte_base, byte_next;
  logic [3:0]       bit_sum;
  logic             start;
  logic             ev_crc, ev_short, ev_long, ev_align, ev_kill;

  logic             done_reg, kill_reg;
  logic             err_crc_reg, err_short_reg, err_long_reg, err_align_reg;
  logic [LEN_W-1:0] frame_len_reg;
  logic [CNT_WIDTH-1:0] good_reg, bad_reg;

  // A frame ends on the first cycle RX sees axiiv low; that cycle is EVAL.
  always_comb begin
    state_cur = state_reg;
    if (state_reg == RX && !axiiv) state_cur = EVAL;
  end

  // Start-of-frame mux: the first beat runs from the init value, not the register.
  always_comb begin
    start     = (state_cur == IDLE) && axiiv;
    crc_base  = start ? CRC32_INIT : crc_reg;
    bit_base  = start ? 3'd0 : bit_reg;
    byte_base = start ? '0 : byte_reg;
    bit_sum   = {1'b0, bit_base} + 4'(DATA_WIDTH);
    bit_next  = bit_sum[2:0];
    byte_next = byte_base;
    if (bit_sum[3] && byte_base != LEN_SAT) byte_next = byte_base + LEN_W'(1);
  end

  crc32_step #(.DATA_WIDTH(DATA_WIDTH)) u_crc_step (
    .crc_in  (crc_base),
    .data    (axiid),
    .crc_out (crc_next)
  );

  // Frame verdict from the accumulated CRC, byte count and leftover bits.
  always_comb begin
    ev_crc   = (crc_reg != CRC_RESIDUE);
    ev_short = (byte_reg < LEN_W'(MIN_BYTES));
    ev_long  = (byte_reg > LEN_W'(MAX_BYTES));
    ev_align = (bit_reg != 3'd0);
    ev_kill  = ev_crc | ev_short | ev_long | ev_align;
  end

  // Frame FSM, accumulators, held status and saturating frame counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      crc_reg       <= CRC32_INIT;
      bit_reg       <= 3'd0;
      byte_reg      <= '0;
      done_reg      <= 1'b0;
      kill_reg      <= 1'b0;
      err_crc_reg   <= 1'b0;
      err_short_reg <= 1'b0;
      err_long_reg  <= 1'b0;
      err_align_reg <= 1'b0;
      frame_len_reg <= '0;
      good_reg      <= '0;
      bad_reg       <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_cur)
        IDLE: begin
          if (axiiv) begin
            state_reg     <= RX;
            crc_reg       <= crc_next;
            bit_reg       <= bit_next;
            byte_reg      <= byte_next;
            kill_reg      <= 1'b0;
            err_crc_reg   <= 1'b0;
            err_short_reg <= 1'b0;
            err_long_reg  <= 1'b0;
            err_align_reg <= 1'b0;
            frame_len_reg <= '0;
          end
        end
        RX: begin
          crc_reg  <= crc_next;
          bit_reg  <= bit_next;
          byte_reg <= byte_next;
        end
        EVAL: begin
          state_reg     <= IDLE;
          done_reg      <= 1'b1;
          kill_reg      <= ev_kill;
          err_crc_reg   <= ev_crc;
          err_short_reg <= ev_short;
          err_long_reg  <= ev_long;
          err_align_reg <= ev_align;
          frame_len_reg <= byte_reg;
          if (ev_kill) begin
            if (bad_reg != '1) bad_reg <= bad_reg + CNT_WIDTH'(1);
          end else begin
            if (good_reg != '1) good_reg <= good_reg + CNT_WIDTH'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign done      = done_reg;
  assign kill      = kill_reg;
  assign err_crc   = err_crc_reg;
  assign err_short = err_short_reg;
  assign err_long  = err_long_reg;
  assign err_align = err_align_reg;
  assign frame_len = frame_len_reg;
  assign good_cnt  = good_reg;
  assign bad_cnt   = bad_reg;

endmodule

// File: tb/tb_fcs_check.sv
// Directed bench for fcs_check: byte-wide and dibit instances with a short
// minimum length, plus a default-parameter instance for length limits.
module tb_fcs_check;

  logic clk = 1'b0;
  logic rst;
  logic       v   [3];
  logic [7:0] din [3];

  logic        done_o [3];
  logic        kill_o [3];
  logic        ec_o   [3];
  logic        es_o   [3];
  logic        el_o   [3];
  logic        ea_o   [3];
  logic [10:0] len_o  [3];
  logic [15:0] good_o [3];
  logic [15:0] bad_o  [3];

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] frm [$];

  always #5 clk = ~clk;

  fcs_check #(.DATA_WIDTH(8), .MIN_BYTES(13)) dut_b8 (
    .clk(clk), .rst(rst), .axiiv(v[0]), .axiid(din[0]),
    .done(done_o[0]), .kill(kill_o[0]), .err_crc(ec_o[0]), .err_short(es_o[0]),
    .err_long(el_o[0]), .err_align(ea_o[0]), .frame_len(len_o[0]),
    .good_cnt(good_o[0]), .bad_cnt(bad_o[0])
  );

  fcs_check #(.DATA_WIDTH(2), .MIN_BYTES(13)) dut_d2 (
    .clk(clk), .rst(rst), .axiiv(v[1]), .axiid(din[1][1:0]),
    .done(done_o[1]), .kill(kill_o[1]), .err_crc(ec_o[1]), .err_short(es_o[1]),
    .err_long(el_o[1]), .err_align(ea_o[1]), .frame_len(len_o[1]),
    .good_cnt(good_o[1]), .bad_cnt(bad_o[1])
  );

  fcs_check dut_def (
    .clk(clk), .rst(rst), .axiiv(v[2]), .axiid(din[2][1:0]),
    .done(done_o[2]), .kill(kill_o[2]), .err_crc(ec_o[2]), .err_short(es_o[2]),
    .err_long(el_o[2]), .err_align(ea_o[2]), .frame_len(len_o[2]),
    .good_cnt(good_o[2]), .bad_cnt(bad_o[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reflected (0xEDB88320) reference CRC over frm[0..n-1], complemented.
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic append_fcs();
    logic [31:0] f;
    f = fcs_of(frm.size());
    frm.push_back(f[7:0]);
    frm.push_back(f[15:8]);
    frm.push_back(f[23:16]);
    frm.push_back(f[31:24]);
  endtask

  task automatic load_ref();
    frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
  endtask

  // Drive frm as beats on instance s; leaves the last beat on the bus.
  task automatic drive_beats(input int s, input bit extra, input bit skip_first);
    int nb;
    nb = (s == 0) ? frm.size() : frm.size() * 4 + (extra ? 1 : 0);
    for (int i = 0; i < nb; i++) begin
      if (i > 0 || !skip_first) @(negedge clk);
      v[s] = 1'b1;
      if (s == 0) din[0] = frm[i];
      else if (i < frm.size() * 4) begin
        logic [7:0] b;
        b = frm[i / 4];
        din[s] = {6'b0, b[2 * (i % 4) +: 2]};
      end else din[s] = 8'h02;
    end
  endtask

  // Drop valid, then expect done exactly two cycles after the last beat.
  task automatic end_frame(input int s);
    @(negedge clk);
    v[s] = 1'b0;
    chk("done_early", done_o[s], 0);
    @(negedge clk);
    chk("done_lat", done_o[s], 1);
  endtask

  task automatic exp_status(input int s, input bit k, input bit c, input bit sh,
                            input bit lo, input bit al, input int len);
    chk("kill", kill_o[s], k);
    chk("err_crc", ec_o[s], c);
    chk("err_short", es_o[s], sh);
    chk("err_long", el_o[s], lo);
    chk("err_align", ea_o[s], al);
    chk("frame_len", len_o[s], len);
    $display("frame dut%0d len=%0d kill=%0b crc=%0b short=%0b long=%0b align=%0b good=%0d bad=%0d",
             s, len_o[s], kill_o[s], ec_o[s], es_o[s], el_o[s], ea_o[s], good_o[s], bad_o[s]);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      v[s]   = 1'b0;
      din[s] = 8'h00;
    end
    repeat (3) @(negedge clk);

    // Reset state on every instance.
    for (int s = 0; s < 3; s++) begin
      chk("rst_done", done_o[s], 0);
      chk("rst_kill", kill_o[s], 0);
      chk("rst_errs", {ec_o[s], es_o[s], el_o[s], ea_o[s]}, 0);
      chk("rst_len", len_o[s], 0);
      chk("rst_good", good_o[s], 0);
      chk("rst_bad", bad_o[s], 0);
    end
    rst = 1'b0;

    // 1: good 13-byte frame, byte beats.
    load_ref();
    drive_beats(0, 0, 0);
    end_frame(0);
    exp_status(0, 0, 0, 0, 0, 0, 13);
    chk("good_cnt_1", good_o[0], 1);
    chk("bad_cnt_1", bad_o[0], 0);
    @(negedge clk);
    chk("done_pulse", done_o[0], 0);
    chk("len_held", len_o[0], 13);

    // 2: corrupted fifth byte.
    frm[4] = 8'h00;
    drive_beats(0, 0, 0);
    end_frame(0);
    exp_status(0, 1, 1, 0, 0, 0, 13);
    chk("bad_cnt_2", bad_o[0], 1);
    chk("good_cnt_2", good_o[0], 1);

    // 3: dibit instance, good frame then one extra dibit, then a single-beat frame.
    load_ref();
    drive_beats(1, 0, 0);
    end_frame(1);
    exp_status(1, 0, 0, 0, 0, 0, 13);
    chk("good_cnt_3", good_o[1], 1);
    drive_beats(1, 1, 0);
    end_frame(1);
    exp_status(1, 1, 1, 0, 0, 1, 13);
    chk("bad_cnt_3", bad_o[1], 1);
    frm.delete();
    drive_beats(1, 1, 0);
    end_frame(1);
    chk("one_kill", kill_o[1], 1);
    chk("one_short", es_o[1], 1);
    chk("one_align", ea_o[1], 1);
    chk("one_len", len_o[1], 0);
    $display("frame dut1 len=%0d kill=%0b short=%0b align=%0b", len_o[1], kill_o[1], es_o[1], ea_o[1]);

    // 4: default limits: 60-byte good-FCS frame, 64-byte good frame, 1600-byte frame.
    frm.delete();
    for (int i = 0; i < 56; i++) frm.push_back(8'(i * 7 + 3));
    append_fcs();
    drive_beats(2, 0, 0);
    end_frame(2);
    exp_status(2, 1, 0, 1, 0, 0, 60);
    frm.delete();
    for (int i = 0; i < 60; i++) frm.push_back(8'(i * 13 + 1));
    append_fcs();
    drive_beats(2, 0, 0);
    end_frame(2);
    exp_status(2, 0, 0, 0, 0, 0, 64);
    chk("good_cnt_4", good_o[2], 1);
    frm.delete();
    for (int i = 0; i < 1600; i++) frm.push_back(8'(i));
    drive_beats(2, 0, 0);
    end_frame(2);
    chk("long_kill", kill_o[2], 1);
    chk("long_err", el_o[2], 1);
    chk("long_short", es_o[2], 0);
    chk("long_align", ea_o[2], 0);
    chk("long_len", len_o[2], 1519);
    $display("frame dut2 len=%0d kill=%0b long=%0b", len_o[2], kill_o[2], el_o[2]);
    chk("bad_cnt_4", bad_o[2], 2);

    // 5: back-to-back good frames, second starting in the done cycle.
    pulse_reset();
    load_ref();
    drive_beats(0, 0, 0);
    @(negedge clk);
    v[0] = 1'b0;
    chk("b2b_gap", done_o[0], 0);
    @(negedge clk);
    chk("b2b_done1", done_o[0], 1);
    chk("b2b_kill1", kill_o[0], 0);
    chk("b2b_len1", len_o[0], 13);
    chk("b2b_good1", good_o[0], 1);
    $display("frame dut0 len=%0d kill=%0b good=%0d (first of pair)", len_o[0], kill_o[0], good_o[0]);
    drive_beats(0, 0, 1);
    chk("b2b_len_clr", len_o[0], 0);
    chk("b2b_no_done", done_o[0], 0);
    end_frame(0);
    exp_status(0, 0, 0, 0, 0, 0, 13);
    chk("b2b_good2", good_o[0], 2);

    // 6: reset mid-frame aborts it silently, then a good frame.
    pulse_reset();
    chk("rst_good6", good_o[0], 0);
    frm = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    drive_beats(0, 0, 0);
    @(negedge clk);
    din[0] = 8'h36;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    v[0] = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      pulses += int'(done_o[0]);
    end
    chk("abort_nodone", pulses, 0);
    chk("abort_good", good_o[0], 0);
    chk("abort_bad", bad_o[0], 0);
    load_ref();
    drive_beats(0, 0, 0);
    end_frame(0);
    exp_status(0, 0, 0, 0, 0, 0, 13);
    chk("post_abort_good", good_o[0], 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
